// File: rtl/multiplier_control_unit_if.sv
// Control bundle between the shift-add multiplier sequencer and its datapath/front panel.
// master: the side that requests runs and supplies the multiplier LSB; slave: the sequencer.
interface multiplier_control_unit_if;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic ClearA;
  logic Clr_Ld;
  logic Add;
  logic Sub;
  logic Shift;
  logic Busy;
  logic Done;

  modport master (
    output Run, ClearA_LoadB, M,
    input  ClearA, Clr_Ld, Add, Sub, Shift, Busy, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, M,
    output ClearA, Clr_Ld, Add, Sub, Shift, Busy, Done
  );
endinterface

// File: rtl/multiplier_control_unit.sv
// Sequencer for an N_BITS signed shift-add multiplier: CLEAR, then ADD/SHIFT pairs per bit,
// subtracting on the sign bit, then HOLD until Run is released.
module multiplier_control_unit #(
  parameter int N_BITS = 8
) (
  input logic                     Clk,
  input logic                     Reset,
  multiplier_control_unit_if.slave bus
);

  localparam int KW = (N_BITS > 2) ? $clog2(N_BITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ADD,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          idle_q, idle_d;
  logic          clear_a_q, clear_a_d;
  logic          add_sel_q, add_sel_d;
  logic          sub_sel_q, sub_sel_d;
  logic          shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Run) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        k_d     = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (k_q == K_LAST) begin
          state_d = S_HOLD;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_ADD;
        end
      end
      S_HOLD: begin
        if (!bus.Run) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are flop-driven in the state they describe.
    idle_d    = (state_d == S_IDLE);
    clear_a_d = (state_d == S_CLEAR);
    add_sel_d = (state_d == S_ADD) && (k_d != K_LAST);
    sub_sel_d = (state_d == S_ADD) && (k_d == K_LAST);
    shift_d   = (state_d == S_SHIFT);
    busy_d    = (state_d == S_CLEAR) || (state_d == S_ADD) || (state_d == S_SHIFT);
    done_d    = (state_d == S_HOLD);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      idle_q    <= 1'b1;
      clear_a_q <= 1'b0;
      add_sel_q <= 1'b0;
      sub_sel_q <= 1'b0;
      shift_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      idle_q    <= idle_d;
      clear_a_q <= clear_a_d;
      add_sel_q <= add_sel_d;
      sub_sel_q <= sub_sel_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Load request only in IDLE and only when no run is being requested in the same cycle.
  assign bus.Clr_Ld = idle_q & bus.ClearA_LoadB & ~bus.Run;
  assign bus.ClearA = clear_a_q;
  assign bus.Add    = add_sel_q & bus.M;
  assign bus.Sub    = sub_sel_q & bus.M;
  assign bus.Shift  = shift_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;

endmodule
